// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and fetch-stage types used by fetch and control.
package riscv_pkg;

  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] ITYPE = 7'b0010011;

  // addi x0,x0,0 -- presented to decode whenever no instruction is held.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between fetch and decode; flush wins over load.
module fetch_out_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
    end else if (flush) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
    end else if (load) begin
      instr_valid <= 1'b1;
      instr       <= load_instr;
      instr_pc    <= load_pc;
    end else if (instr_valid && ready) begin
      // Consumed with nothing to replace it: fall back to the NOP image.
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, variable-latency imem requests, redirect/drop handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  pend_pc;
  logic         drop;
  logic         can_issue;
  logic         resp_load;
  logic [31:0]  redirect_pc;

  assign redirect_pc = branch_target & ~32'h3;
  assign can_issue   = !instr_valid || instr_ready;
  assign imem_req    = !rst && !PCSrc && (state == ISSUE) && can_issue;
  assign imem_addr   = pc_q;
  assign resp_load   = (state == WAIT) && imem_rvalid && !drop;
  assign opcode      = instr[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ISSUE;
      pc_q    <= RESET_PC;
      pend_pc <= 32'h0;
      drop    <= 1'b0;
    end else if (PCSrc) begin
      pc_q <= redirect_pc;
      if (state == WAIT) begin
        // A response arriving now is simply discarded; otherwise mark the
        // outstanding one for dropping when it eventually returns.
        if (imem_rvalid) begin
          state <= ISSUE;
          drop  <= 1'b0;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      case (state)
        ISSUE: begin
          if (imem_req) begin
            pc_q    <= pc_q + 32'd4;
            pend_pc <= pc_q;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  fetch_out_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .flush      (PCSrc),
    .load       (resp_load),
    .load_instr (imem_rdata),
    .load_pc    (pend_pc),
    .ready      (instr_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

`ifdef FETCH_PERF_EN
  logic flush_hit;

  // A redirect only counts as a flush when it actually throws work away.
  assign flush_hit = PCSrc && (instr_valid || ((state == WAIT) && !drop));

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h0;
      flush_count <= 16'h0;
    end else begin
      if (instr_valid && instr_ready) fetch_count <= fetch_count + 32'd1;
      if (flush_hit) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a request-queue reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pcsrc, rvalid, ready;
  logic [31:0] target, rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [6:0]  opcode;
  logic [31:0] fetch_count_w;
  logic [15:0] flush_count_w;

  logic        rst_w, rvalid_w, ready_w;
  logic [31:0] rdata_w;
  logic        req_w, valid_w;
  logic [31:0] addr_w, instr_w, pc_w;
  logic [6:0]  op_w;
  logic [31:0] fc_w2;
  logic [15:0] flc_w2;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .PCSrc(pcsrc), .branch_target(target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .instr_valid(instr_valid), .instr_ready(ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count_w), .flush_count(flush_count_w)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .PCSrc(1'b0), .branch_target(32'h0),
    .imem_req(req_w), .imem_addr(addr_w),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .instr_valid(valid_w), .instr_ready(ready_w),
    .instr(instr_w), .instr_pc(pc_w), .opcode(op_w)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc_w2), .flush_count(flc_w2)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    bit          killed;
    int          rem;
    logic [31:0] data;
  } req_t;

  req_t        q[$];
  logic [31:0] m_pc, m_hi, m_hp;
  bit          m_hv;
  int unsigned m_fetch, m_flush;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check combinational request, advance model, check registers.
  task automatic step(input bit r, input bit ps, input logic [31:0] tg, input bit rdy, input int lat);
    bit   rv, ereq;
    req_t e;
    rst = r; pcsrc = ps; target = tg; ready = rdy;
    rv = !r && (q.size() > 0) && (q[0].rem <= 1);
    rvalid = rv;
    rdata  = rv ? q[0].data : $urandom;
    #1;
    ereq = !r && !ps && (q.size() == 0) && (!m_hv || rdy);
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    if (r) begin
      q.delete();
      m_pc = RST_PC; m_hv = 0; m_hi = NOP; m_hp = 32'h0;
      m_fetch = 0; m_flush = 0;
    end else begin
      if (m_hv && rdy) m_fetch++;
      if (ps && (m_hv || (q.size() > 0 && !q[0].killed))) m_flush++;
      if (m_hv && rdy) begin m_hv = 0; m_hi = NOP; end
      if (rv) begin
        e = q.pop_front();
        if (!e.killed && !ps) begin m_hv = 1; m_hi = e.data; m_hp = e.addr; end
      end
      if (ps) begin
        m_pc = tg & ~32'h3; m_hv = 0; m_hi = NOP;
        foreach (q[i]) q[i].killed = 1;
      end
      foreach (q[i]) q[i].rem--;
      if (ereq) begin
        e.addr = m_pc; e.killed = 0; e.rem = lat;
        e.data = (m_pc == 32'h0) ? 32'h0050_0093 : $urandom;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hv});
    chk("instr", instr, m_hi);
    if (m_hv || r) chk("instr_pc", instr_pc, m_hp);
    chk("opcode", {25'b0, opcode}, {25'b0, m_hi[6:0]});
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count_w, m_fetch);
    chk("flush_count", {16'b0, flush_count_w}, {16'b0, m_flush[15:0]});
`endif
  endtask

  initial begin
    bit got;
    rst = 1; pcsrc = 0; target = 0; ready = 0; rvalid = 0; rdata = 0;
    rst_w = 1; rvalid_w = 0; ready_w = 0; rdata_w = 0;
    m_pc = RST_PC; m_hv = 0; m_hi = NOP; m_hp = 0; m_fetch = 0; m_flush = 0;

    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    // 1-cycle memory, decode always ready
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("tp1_pc", instr_pc, 32'h0);
    chk("tp1_op", {25'b0, opcode}, {25'b0, 7'b0010011});
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // decode stall then release
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // redirect while a 3-cycle request to 0x10 is outstanding
    step(1, 0, 0, 1, 1);
    step(0, 1, 32'h10, 1, 1);
    step(0, 0, 0, 1, 3);
    step(0, 1, 32'h103, 1, 1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0, 0, 0, 1, 1);
      got = instr_valid;
    end
    chk("tp3_seen", {31'b0, got}, 32'h1);
    chk("tp3_pc", instr_pc, 32'h100);

    // redirect in the same cycle as the response
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h40, 1, 1);
    chk("tp4_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // reset while waiting on memory
    step(0, 0, 0, 1, 3);
    step(1, 0, 0, 1, 1);
    chk("tp5_instr", instr, NOP);
    step(0, 0, 0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 64) == 0, ($urandom % 8) == 0, $urandom,
           ($urandom % 4) != 0, 1 + ($urandom % 3));

    // PC wrap from 0xFFFF_FFFC on the second instance
    rst = 0; pcsrc = 0; ready = 1;
    @(posedge clk); #1;
    rst_w = 0; ready_w = 1;
    #1;
    chk("wrap_req0", {31'b0, req_w}, 32'h1);
    chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rvalid_w = 1; rdata_w = 32'h0050_0093;
    #1;
    chk("wrap_req_wait", {31'b0, req_w}, 32'h0);
    @(posedge clk); #1;
    rvalid_w = 0;
    chk("wrap_valid", {31'b0, valid_w}, 32'h1);
    chk("wrap_pc", pc_w, 32'hFFFF_FFFC);
    chk("wrap_req1", {31'b0, req_w}, 32'h1);
    chk("wrap_addr1", addr_w, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
